// File: rtl/lif_aer_pkg.sv
// Shared constants and the AER word type for the spike-to-address-event encoder.
// AER_TIMESTAMP_EN widens each word with the timestep stamp in the MSBs.
package lif_aer_pkg;
    localparam int N_NEURONS = 8;
    localparam int ADDR_W    = 3;
    localparam int TS_W      = 4;
`ifdef AER_TIMESTAMP_EN
    localparam int AER_W     = TS_W + ADDR_W;
`else
    localparam int AER_W     = ADDR_W;
`endif

    typedef logic [AER_W-1:0] aer_word_t;
endpackage

// File: rtl/lif_aer_fifo.sv
// DEPTH-entry synchronous event FIFO; head is read straight from the storage registers.
// Head reads as zero while empty so the output never shows stale entries.
module lif_aer_fifo
    import lif_aer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  logic      i_pop,
    input  aer_word_t i_data,
    output aer_word_t o_head,
    output logic      o_full,
    output logic      o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    aer_word_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/lif_aer_encoder.sv
// Converts each timestep's spike vector into AER words, lowest neuron index first, one per cycle.
// AER_TIMESTAMP_EN: when defined, each word carries the capture timestep in its MSBs.
module lif_aer_encoder
    import lif_aer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_NEURONS-1:0] spike_vec,
    input  logic                 spike_valid,
    output logic                 spike_ready,
    output logic [AER_W-1:0]     aer_data,
    output logic                 aer_valid,
    input  logic                 aer_ready,
    output logic                 overflow,
    input  logic                 clr_ovf,
    output logic [7:0]           drop_cnt
);
    logic [N_NEURONS-1:0] r_pending;
    logic [TS_W-1:0]      r_ts_cnt;
    logic                 r_overflow;
    logic [7:0]           r_drop_cnt;
`ifdef AER_TIMESTAMP_EN
    logic [TS_W-1:0]      r_ts_cur;
`endif

    logic [ADDR_W-1:0]    w_idx;
    aer_word_t            w_word;
    aer_word_t            w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_capture;
    logic                 w_drop;
    logic                 w_push;

    // Lowest set bit wins: scanning downward leaves the smallest index last.
    always_comb begin
        w_idx = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (r_pending[i]) w_idx = ADDR_W'(i);
        end
    end

`ifdef AER_TIMESTAMP_EN
    assign w_word = {r_ts_cur, w_idx};
`else
    assign w_word = w_idx;
`endif

    assign spike_ready = (r_pending == '0);
    assign w_capture   = spike_valid & spike_ready;
    assign w_drop      = spike_valid & ~spike_ready;
    assign w_push      = (r_pending != '0) & ~w_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending  <= '0;
            r_ts_cnt   <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_capture) begin
                r_pending <= spike_vec;
            end else if (w_push) begin
                // x & (x-1) clears exactly the lowest set bit just encoded
                r_pending <= r_pending & (r_pending - 1'b1);
            end
            if (spike_valid) r_ts_cnt <= r_ts_cnt + 1'b1;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef AER_TIMESTAMP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts_cur <= '0;
        end else if (w_capture) begin
            r_ts_cur <= r_ts_cnt;
        end
    end
`endif

    lif_aer_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (aer_ready),
        .i_data  (w_word),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign aer_data  = w_head;
    assign aer_valid = ~w_empty;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_lif_aer_encoder.sv
// Randomised and directed bench for lif_aer_encoder against a queue-level event model.
// Works with or without AER_TIMESTAMP_EN defined.
module tb_lif_aer_encoder;
    import lif_aer_pkg::*;

    localparam int DEPTH = 4;

    logic                 clk;
    logic                 rst;
    logic [N_NEURONS-1:0] spike_vec;
    logic                 spike_valid;
    logic                 spike_ready;
    logic [AER_W-1:0]     aer_data;
    logic                 aer_valid;
    logic                 aer_ready;
    logic                 overflow;
    logic                 clr_ovf;
    logic [7:0]           drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: words waiting to be encoded, words buffered, and the counters.
    aer_word_t m_pend[$];
    aer_word_t m_fifo[$];
    int        m_ts;
    bit        m_ovf;
    int        m_drop;

    lif_aer_encoder #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .spike_vec   (spike_vec),
        .spike_valid (spike_valid),
        .spike_ready (spike_ready),
        .aer_data    (aer_data),
        .aer_valid   (aer_valid),
        .aer_ready   (aer_ready),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf),
        .drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic aer_word_t mk_word(input int ts, input int idx);
`ifdef AER_TIMESTAMP_EN
        return aer_word_t'((ts << ADDR_W) | idx);
`else
        return aer_word_t'(idx);
`endif
    endfunction

    task automatic model_clear();
        m_pend.delete();
        m_fifo.delete();
        m_ts   = 0;
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic model_edge(input logic [N_NEURONS-1:0] vec, input bit valid,
                              input bit ready, input bit clr);
        bit full0  = (m_fifo.size() == DEPTH);
        bit idle0  = (m_pend.size() == 0);
        if (ready && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (!idle0 && !full0) m_fifo.push_back(m_pend.pop_front());
        if (valid && idle0) begin
            for (int i = 0; i < N_NEURONS; i++)
                if (vec[i]) m_pend.push_back(mk_word(m_ts, i));
        end
        if (valid && !idle0) begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
        end else if (clr) begin
            m_ovf = 1'b0;
        end
        if (valid) m_ts = (m_ts + 1) % (1 << TS_W);
    endtask

    task automatic compare_all();
        check("spike_ready", 32'(spike_ready), 32'(m_pend.size() == 0));
        check("aer_valid",   32'(aer_valid),   32'(m_fifo.size() != 0));
        check("aer_data",    32'(aer_data),    (m_fifo.size() != 0) ? 32'(m_fifo[0]) : 32'd0);
        check("overflow",    32'(overflow),    32'(m_ovf));
        check("drop_cnt",    32'(drop_cnt),    32'(m_drop));
    endtask

    // One clock: drive after the falling edge, update model at the rising edge, compare at the next fall.
    task automatic cycle(input logic [N_NEURONS-1:0] vec, input bit valid,
                         input bit ready, input bit clr);
        spike_vec   = vec;
        spike_valid = valid;
        aer_ready   = ready;
        clr_ovf     = clr;
        @(posedge clk);
        model_edge(vec, valid, ready, clr);
        @(negedge clk);
        $display("[TB] vec=%02h v=%0b r=%0b clr=%0b -> rdy=%0b aer_v=%0b aer_d=%0h ovf=%0b drops=%0d",
                 vec, valid, ready, clr, spike_ready, aer_valid, aer_data, overflow, drop_cnt);
        compare_all();
    endtask

    task automatic idle(input int n, input bit ready);
        for (int i = 0; i < n; i++) cycle('0, 1'b0, ready, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for a clock.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_clear();
        check("rst_aer_valid",   32'(aer_valid),   32'd0);
        check("rst_spike_ready", 32'(spike_ready), 32'd1);
        check("rst_aer_data",    32'(aer_data),    32'd0);
        check("rst_overflow",    32'(overflow),    32'd0);
        check("rst_drop_cnt",    32'(drop_cnt),    32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        spike_vec   = '0;
        spike_valid = 1'b0;
        aer_ready   = 1'b0;
        clr_ovf     = 1'b0;
        model_clear();
        #2;
        do_reset();

        // Single event, then multi-bit order at ts=3
        cycle(8'b0000_0100, 1'b1, 1'b1, 1'b0);
        idle(4, 1'b1);
        cycle(8'h00, 1'b1, 1'b1, 1'b0);
        cycle(8'h00, 1'b1, 1'b1, 1'b0);
        cycle(8'b1010_0001, 1'b1, 1'b1, 1'b0);
        idle(5, 1'b1);

        // Backpressure: FIFO fills, head held, then drained in order
        cycle(8'hFF, 1'b1, 1'b0, 1'b0);
        idle(8, 1'b0);
        idle(12, 1'b1);

        // Drop, clear, then saturating drop counter
        cycle(8'h0F, 1'b1, 1'b0, 1'b0);
        cycle(8'h55, 1'b1, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0, 1'b1);
        idle(8, 1'b1);
        cycle(8'hFF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) cycle(8'hFF, 1'b1, 1'b0, 1'b0);
        check("drop_saturated", 32'(drop_cnt), 32'd255);
        cycle(8'h00, 1'b1, 1'b1, 1'b1);
        idle(12, 1'b1);

        // Timestep wrap: 16 empty vectors bring the stamp back to zero
        do_reset();
        for (int i = 0; i < 16; i++) cycle(8'h00, 1'b1, 1'b1, 1'b0);
        cycle(8'h01, 1'b1, 1'b1, 1'b0);
        check("wrap_word", 32'(aer_data), 32'(mk_word(0, 0)));
        idle(3, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            logic [N_NEURONS-1:0] v;
            v = ($urandom_range(0, 4) == 0) ? '0 : N_NEURONS'($urandom);
            cycle(v, $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 9) == 0);
        end
        idle(20, 1'b1);

        // Reset mid-burst: nothing may emerge afterwards
        cycle(8'hFF, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);
        do_reset();
        idle(10, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
